// File: rtl/simmem_pkg.sv
// Shared types and sizing for the simulated memory controller.
package simmem_pkg;

    localparam int unsigned NumIds = 16;
    localparam int unsigned IDWidth = $clog2(NumIds);

    localparam int unsigned WriteRespBankTotalCapacity = 32;
    localparam int unsigned WriteRespBankAddrWidth = $clog2(WriteRespBankTotalCapacity);
    localparam int unsigned WriteRespMetadataWidth = WriteRespBankAddrWidth;

    localparam int unsigned WriteRespContentWidth = 3;

    typedef struct packed {
        logic [IDWidth-1:0]               id;
        logic [WriteRespContentWidth-1:0] content;
    } write_resp_t;

    // Link to the next slot of the same ID's list.
    typedef logic [WriteRespMetadataWidth-1:0] write_resp_metadata_e;

endpackage

// File: rtl/simmem_id_arbiter.sv
// Picks one eligible ID and holds the choice while the consumer stalls.
// SIMMEM_WRESP_RR_ARB_EN selects round-robin; otherwise lowest index wins.
module simmem_id_arbiter
    import simmem_pkg::*;
#(
    parameter int unsigned NumReq = NumIds,
    parameter int unsigned IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NumReq-1:0] req_i,
    input  logic              ack_i,
    output logic [NumReq-1:0] gnt_o,
    output logic [IdxW-1:0]   gnt_idx_o,
    output logic              gnt_valid_o
);

    logic            locked_q;
    logic [IdxW-1:0] locked_idx_q;
    logic [IdxW-1:0] pick_idx;
    logic            pick_valid;

`ifdef SIMMEM_WRESP_RR_ARB_EN
    logic [IdxW-1:0] last_q;

    // Smallest distance after the last served ID wins, so scan far-to-near.
    always_comb begin
        pick_idx   = '0;
        pick_valid = 1'b0;
        for (int k = NumReq; k >= 1; k--) begin
            if (req_i[IdxW'((int'(last_q) + k) % NumReq)]) begin
                pick_idx   = IdxW'((int'(last_q) + k) % NumReq);
                pick_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= IdxW'(NumReq - 1);
        end else if (gnt_valid_o && ack_i) begin
            last_q <= gnt_idx_o;
        end
    end
`else
    always_comb begin
        pick_idx   = '0;
        pick_valid = 1'b0;
        for (int i = NumReq - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                pick_idx   = IdxW'(i);
                pick_valid = 1'b1;
            end
        end
    end
`endif

    // A stalled grant is kept as long as its requester stays eligible.
    always_comb begin
        gnt_idx_o   = pick_idx;
        gnt_valid_o = pick_valid;
        if (locked_q && req_i[locked_idx_q]) begin
            gnt_idx_o   = locked_idx_q;
            gnt_valid_o = 1'b1;
        end
        gnt_o = '0;
        if (gnt_valid_o) begin
            gnt_o[gnt_idx_o] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            locked_q     <= 1'b0;
            locked_idx_q <= '0;
        end else begin
            locked_q     <= gnt_valid_o & ~ack_i;
            locked_idx_q <= gnt_idx_o;
        end
    end

endmodule

// File: rtl/simmem_write_resp_bank.sv
// Per-ID write-response storage as linked lists over one shared slot array.
// Release arbitration policy is chosen by SIMMEM_WRESP_RR_ARB_EN (see simmem_id_arbiter).
module simmem_write_resp_bank
    import simmem_pkg::*;
#(
    parameter int unsigned TotalCapacity = WriteRespBankTotalCapacity,
    parameter int unsigned NumIds        = simmem_pkg::NumIds
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [IDWidth-1:0]                res_req_id_i,
    input  logic                              res_req_valid_i,
    output logic                              res_req_ready_o,
    output logic [WriteRespBankAddrWidth-1:0] res_addr_o,
    input  write_resp_t                       in_data_i,
    input  logic                              in_data_valid_i,
    output logic                              in_data_ready_o,
    input  logic [NumIds-1:0]                 release_en_i,
    output write_resp_t                       out_data_o,
    output logic                              out_data_valid_o,
    input  logic                              out_data_ready_i
);

    localparam int unsigned AddrW = WriteRespBankAddrWidth;
    localparam int unsigned CntW  = $clog2(TotalCapacity + 1);

    write_resp_t          data_q     [TotalCapacity];
    write_resp_metadata_e nxt_elem_q [TotalCapacity];
    logic [TotalCapacity-1:0] reserved_q;
    logic [TotalCapacity-1:0] filled_q;

    write_resp_metadata_e head_q    [NumIds];
    write_resp_metadata_e tail_q    [NumIds];
    write_resp_metadata_e fill_q    [NumIds];
    logic [CntW-1:0]      pending_q [NumIds];
    logic [NumIds-1:0]    nonempty_q;

    logic [AddrW-1:0]   free_idx;
    logic               free_any;
    logic               res_hs;
    logic               fill_hs;
    logic               pop_hs;
    write_resp_metadata_e fill_slot;
    write_resp_metadata_e pop_slot;
    logic [NumIds-1:0]  eligible;
    logic [NumIds-1:0]  grant_oh;
    logic [IDWidth-1:0] grant_idx;
    logic               grant_valid;
    logic [NumIds-1:0]  push_oh;
    logic [NumIds-1:0]  fill_oh;
    logic [NumIds-1:0]  pop_oh;

    // Lowest unreserved slot; a slot freed this cycle only shows up next cycle.
    always_comb begin
        free_idx = '0;
        free_any = 1'b0;
        for (int s = TotalCapacity - 1; s >= 0; s--) begin
            if (!reserved_q[s]) begin
                free_idx = AddrW'(s);
                free_any = 1'b1;
            end
        end
    end

    assign res_req_ready_o = free_any;
    assign res_addr_o      = free_idx;
    assign res_hs          = res_req_valid_i & free_any;

    assign in_data_ready_o = (pending_q[in_data_i.id] != '0);
    assign fill_hs         = in_data_valid_i & in_data_ready_o;
    assign fill_slot       = fill_q[in_data_i.id];

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NumIds; i++) begin
            eligible[i] = release_en_i[i] & nonempty_q[i] & filled_q[head_q[i]];
        end
    end

    simmem_id_arbiter #(
        .NumReq (NumIds),
        .IdxW   (IDWidth)
    ) u_arbiter (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_i       (eligible),
        .ack_i       (out_data_ready_i),
        .gnt_o       (grant_oh),
        .gnt_idx_o   (grant_idx),
        .gnt_valid_o (grant_valid)
    );

    assign pop_slot         = head_q[grant_idx];
    assign out_data_valid_o = grant_valid;
    assign out_data_o       = grant_valid ? data_q[pop_slot] : '0;
    assign pop_hs           = grant_valid & out_data_ready_i;

    always_comb begin
        push_oh = '0;
        fill_oh = '0;
        for (int i = 0; i < NumIds; i++) begin
            push_oh[i] = res_hs && (res_req_id_i == IDWidth'(i));
            fill_oh[i] = fill_hs && (in_data_i.id == IDWidth'(i));
        end
        pop_oh = pop_hs ? grant_oh : '0;
    end

    // Slot storage: fill and pop never target the same slot (unfilled vs filled).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            reserved_q <= '0;
            filled_q   <= '0;
            for (int s = 0; s < TotalCapacity; s++) begin
                data_q[s]     <= '0;
                nxt_elem_q[s] <= '0;
            end
        end else begin
            if (res_hs) begin
                reserved_q[free_idx] <= 1'b1;
                if (nonempty_q[res_req_id_i]) begin
                    nxt_elem_q[tail_q[res_req_id_i]] <= free_idx;
                end
            end
            if (fill_hs) begin
                data_q[fill_slot]   <= in_data_i;
                filled_q[fill_slot] <= 1'b1;
            end
            if (pop_hs) begin
                reserved_q[pop_slot] <= 1'b0;
                filled_q[pop_slot]   <= 1'b0;
            end
        end
    end

    // List pointers; the push branch comes last so it overrides a same-cycle pop or fill.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            nonempty_q <= '0;
            for (int i = 0; i < NumIds; i++) begin
                head_q[i]    <= '0;
                tail_q[i]    <= '0;
                fill_q[i]    <= '0;
                pending_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NumIds; i++) begin
                if (pop_oh[i]) begin
                    if (head_q[i] == tail_q[i]) begin
                        nonempty_q[i] <= 1'b0;
                    end else begin
                        head_q[i] <= nxt_elem_q[head_q[i]];
                    end
                end
                if (fill_oh[i]) begin
                    fill_q[i] <= nxt_elem_q[fill_q[i]];
                end
                if (push_oh[i]) begin
                    tail_q[i] <= free_idx;
                    if (!nonempty_q[i] || (pop_oh[i] && head_q[i] == tail_q[i])) begin
                        head_q[i]     <= free_idx;
                        nonempty_q[i] <= 1'b1;
                    end
                    if (pending_q[i] == '0 || (fill_oh[i] && pending_q[i] == CntW'(1))) begin
                        fill_q[i] <= free_idx;
                    end
                end
                pending_q[i] <= pending_q[i] + CntW'(push_oh[i]) - CntW'(fill_oh[i]);
            end
        end
    end

endmodule
